muldiv_seq: RTL

Parametrised iterative multiply/divide unit for the next-generation CPU datapath. It replaces the fixed 16-bit single-cycle mul/div path with an N-bit, one-bit-per-cycle engine that uses a Start/Busy/Done handshake. It adds signed and unsigned variants of both operations and a defined divide-by-zero result. Results go to HI/LO registers that the register-file write mux reads.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MUL_U = 2'b00,
    MUL_S = 2'b01,
    DIV_U = 2'b10,
    DIV_S = 2'b11
  } funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_t;

  function automatic logic is_signed(funct_t f);
    return f[0];
  endfunction

  function automatic logic is_div(funct_t f);
    return f[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int N = 16
) (
  input  logic [N:0]   acc,
  input  logic [N-1:0] sreg,
  input  logic [N-1:0] mag,
  input  logic         op_div,
  output logic [N:0]   acc_next,
  output logic [N-1:0] sreg_next
);

  logic [N:0] sum;
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    sum       = {1'b0, acc[N-1:0]} + {1'b0, mag};
    shifted   = {acc[N-1:0], sreg[N-1]};
    diff      = shifted - {1'b0, mag};
    acc_next  = acc;
    sreg_next = sreg;
    // Divide: remainder in acc, dividend shifts out of sreg while quotient bits shift in.
    if (op_div) begin
      if (shifted >= {1'b0, mag}) begin
        acc_next  = diff;
        sreg_next = {sreg[N-2:0], 1'b1};
      end else begin
        acc_next  = shifted;
        sreg_next = {sreg[N-2:0], 1'b0};
      end
    end else begin
      if (sreg[0]) begin
        acc_next  = {1'b0, sum[N:1]};
        sreg_next = {sum[0], sreg[N-1:1]};
      end else begin
        acc_next  = {1'b0, acc[N:1]};
        sreg_next = {acc[0], sreg[N-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// N-bit one-bit-per-cycle multiply/divide with Start/Busy/Done handshake and HI/LO results.
// Define MULDIV_EARLY_OUT_EN to let multiplies finish once the remaining multiplier bits are zero.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Start,
  input  logic [1:0]   Funct,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Hi,
  output logic [N-1:0] Lo
);

  localparam int CW = $clog2(N) + 1;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  funct_t         op;
  logic           neg_a, neg_b;
  logic [N:0]     acc, acc_step;
  logic [N-1:0]   sreg, sreg_step, mag;
  logic           last_step;

  funct_t         start_op;
  logic           start_sa, start_sb;
  logic [N-1:0]   mag_a, mag_b;
  logic [2*N-1:0] prod, prod_fix;
  logic [N-1:0]   hi_fix, lo_fix;

  muldiv_step #(.N(N)) u_step (
    .acc       (acc),
    .sreg      (sreg),
    .mag       (mag),
    .op_div    (is_div(op)),
    .acc_next  (acc_step),
    .sreg_next (sreg_step)
  );

  always_comb begin
    start_op = funct_t'(Funct);
    start_sa = is_signed(start_op) & A[N-1];
    start_sb = is_signed(start_op) & B[N-1];
    mag_a    = start_sa ? -A : A;
    mag_b    = start_sb ? -B : B;
  end

`ifdef MULDIV_EARLY_OUT_EN
  // The multiplier bits still to be processed sit in the low cnt-1 bits of sreg after this step.
  logic [N-1:0] rem_mask;
  always_comb begin
    rem_mask  = (N'(1) << (cnt - CW'(1))) - N'(1);
    last_step = (cnt == CW'(1)) || (!is_div(op) && ((sreg_step & rem_mask) == '0));
  end
`else
  always_comb begin
    last_step = (cnt == CW'(1));
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last_step) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef MULDIV_EARLY_OUT_EN
    // An early exit leaves the product aligned high by the count of unprocessed bits.
    prod = {acc[N-1:0], sreg} >> cnt;
`else
    prod = {acc[N-1:0], sreg};
`endif
    prod_fix = (neg_a ^ neg_b) ? -prod : prod;
    hi_fix   = prod_fix[2*N-1:N];
    lo_fix   = prod_fix[N-1:0];
    if (is_div(op)) begin
      hi_fix = neg_a ? -acc[N-1:0] : acc[N-1:0];
      if (mag == '0) lo_fix = '1;
      else           lo_fix = (neg_a ^ neg_b) ? -sreg : sreg;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= MUL_U;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      acc   <= '0;
      sreg  <= '0;
      mag   <= '0;
      Done  <= 1'b0;
      Hi    <= '0;
      Lo    <= '0;
    end else begin
      state <= state_next;
      Done  <= 1'b0;
      case (state)
        IDLE: if (Start) begin
          op    <= start_op;
          neg_a <= start_sa;
          neg_b <= start_sb;
          acc   <= '0;
          cnt   <= CW'(N);
          sreg  <= is_div(start_op) ? mag_a : mag_b;
          mag   <= is_div(start_op) ? mag_b : mag_a;
        end
        RUN: begin
          acc  <= acc_step;
          sreg <= sreg_step;
          cnt  <= cnt - CW'(1);
        end
        FIX: begin
          Hi   <= hi_fix;
          Lo   <= lo_fix;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);

endmodule
